// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit memory controller: access size
// codes, FSM states, fault codes and request legality checking.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_code_t;

  // Illegal size takes priority over misalignment when both apply.
  function automatic fault_code_t check_req(input logic       store,
                                            input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    if (size == 3'b011 || size == 3'b110 || size == 3'b111 || (store && size[2]))
      return FC_ILLEGAL;
    if (size[1:0] == 2'b01 && addr_lo[0])
      return FC_MISALIGN;
    if (size[1:0] == 2'b10 && addr_lo != 2'b00)
      return FC_MISALIGN;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a returned memory word and
// sign- or zero-extends it according to the load size code.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every path of a combinational block assigns its outputs (here via
  // the default arm) so no latch is inferred.
  always_comb begin
    case (size)
      SZ_B:    result = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   result = {24'h000000, byte_sel};
      SZ_H:    result = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory sequencer: accepts one core request at a time, drives
// it onto a valid/ready data bus, and returns aligned load data or a fault.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              core_stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_t            state, state_next;
  fault_code_t       req_chk, code_q;
  logic              store_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_q;
  logic [31:0]       aligned;
  logic [CNT_W-1:0]  cnt;
  logic              accept, timeout, in_req;
  logic [3:0]        strb;
  logic [31:0]       lane_wdata;

  assign req_chk = check_req(req_store, req_size, req_addr[1:0]);
  assign accept  = (state == ST_IDLE) && req_valid && (req_chk == FC_NONE);
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1)) && !mem_rvalid;
  assign in_req  = (state == ST_REQ);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (req_valid) state_next = (req_chk == FC_NONE) ? ST_REQ : ST_FAULT;
      ST_REQ:      if (mem_ready) state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (mem_rvalid)   state_next = ST_DONE;
        else if (timeout) state_next = ST_FAULT;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // NOTE: the request latches carry no memory array, so they are reset along
  // with the rest to keep outputs defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      code_q  <= FC_NONE;
      load_q  <= '0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      cnt <= (state == ST_WAIT_RSP) ? cnt + 1'b1 : '0;
      if (state == ST_IDLE && req_valid && req_chk != FC_NONE)
        code_q <= req_chk;
      else if (state == ST_WAIT_RSP && timeout)
        code_q <= FC_TIMEOUT;
      if (state == ST_WAIT_RSP && mem_rvalid && !store_q)
        load_q <= aligned;
    end
  end

  lsu_load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .result  (aligned)
  );

  // Store data is replicated across lanes; the strobes pick the live bytes.
  always_comb begin
    strb       = 4'b1111;
    lane_wdata = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        strb       = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign core_stall = accept || in_req || (state == ST_WAIT_RSP);
  assign load_valid = (state == ST_DONE) && !store_q;
  assign load_data  = load_q;
  assign fault      = (state == ST_FAULT);
  assign fault_code = code_q;
  assign mem_valid  = in_req;
  assign mem_we     = in_req && store_q;
  assign mem_addr   = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wstrb  = (in_req && store_q) ? strb : 4'b0000;
  assign mem_wdata  = (in_req && store_q) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed corner cases plus randomized
// transactions compared against a behavioural model of the load/store rules.
module tb_lsu_mem_ctrl;

  localparam int TO     = 64;
  localparam int ADDR_W = 32;

  logic              clk, rst_n;
  logic              req_valid, req_store;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              core_stall, load_valid, fault;
  logic [31:0]       load_data;
  logic [1:0]        fault_code;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata, mem_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_ld = '0;

  lsu_mem_ctrl #(.TIMEOUT_CYC(TO), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .core_stall(core_stall), .load_valid(load_valid), .load_data(load_data),
    .fault(fault), .fault_code(fault_code),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        f;
    logic [1:0]  fc;
    logic        saw_valid;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  strb;
    logic        we;
    logic        stable;
    logic        stall_acc;
    logic        stall_busy_ok;
    logic        stall_end;
    int          lat;
    int          wait_cyc;
    logic        hung;
  } obs_t;

  // ---------------- behavioural model ----------------
  function automatic int size_bytes(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [1:0] model_fault(input logic st, input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3 || sz == 6 || sz == 7 || (st && sz >= 4)) return 2'b10;
    if ((a % size_bytes(sz)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int     off;
    off = int'(a % 4);
    case (sz)
      3'b000, 3'b100: begin
        v = longint'((rd >> (8 * off)) & 32'hFF);
        if (sz == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((rd >> (8 * off)) & 32'hFFFF);
        if (sz == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << size_bytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int          nb;
    nb = size_bytes(sz);
    r  = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from an IDLE cycle through DONE/FAULT, acting as the bus.
  task automatic run_txn(input logic st, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_dly, input int rsp_dly, output obs_t o);
    int phase, n, cyc;
    o = '{default: 0};
    o.stable = 1'b1;
    o.stall_busy_ok = 1'b1;
    req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
    #1 o.stall_acc = core_stall;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_store = ~st;
    phase = 0; n = 0; cyc = 1;
    while (cyc < 400) begin
      if (phase == 2) begin
        o.lv = load_valid; o.ld = load_data; o.stall_end = core_stall; o.lat = cyc;
        break;
      end
      if (phase == 0 && mem_valid) begin
        if (!o.saw_valid) begin
          o.maddr = mem_addr; o.mwdata = mem_wdata; o.strb = mem_wstrb; o.we = mem_we;
        end else if (mem_addr !== o.maddr || mem_wdata !== o.mwdata ||
                     mem_wstrb !== o.strb || mem_we !== o.we) begin
          o.stable = 1'b0;
        end
        o.saw_valid = 1'b1;
      end
      if (fault) begin
        o.f = 1'b1; o.fc = fault_code; o.stall_end = core_stall; o.lat = cyc;
        break;
      end
      if (!core_stall) o.stall_busy_ok = 1'b0;
      if (phase == 0) begin
        if (mem_valid) begin
          mem_ready = (n >= rdy_dly);
          n++;
        end
      end else begin
        mem_rvalid = (o.wait_cyc >= rsp_dly);
        mem_rdata  = mem_rvalid ? rd : $urandom;
        o.wait_cyc++;
      end
      step();
      cyc++;
      if (mem_ready)  phase = 1;
      if (mem_rvalid) phase = 2;
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
    end
    if (cyc >= 400) o.hung = 1'b1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_store = 0; req_size = 0; req_addr = '0; req_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) step();
    checks++; if ({core_stall, load_valid, fault, mem_valid, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {core_stall, load_valid, fault, mem_valid, mem_we});
    end
    checks++; if ({load_data, fault_code, mem_wstrb} !== 38'h0) begin
      errors++; $display("FAIL reset_data load_data=%h fault_code=%b wstrb=%b exp=0", load_data, fault_code, mem_wstrb);
    end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_bus addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  szs [3] = '{3'b000, 3'b101, 3'b001};
    logic [31:0] ads [3] = '{32'h103, 32'h102, 32'h102};
    logic [31:0] rds [3] = '{32'h80AABBCC, 32'h80011234, 32'h80011234};
    logic [31:0] exs [3] = '{32'hFFFFFF80, 32'h00008001, 32'hFFFF8001};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, szs[i], ads[i], 32'h0, rds[i], 0, 0, o);
      checks++; if (o.lv !== 1'b1 || o.ld !== exs[i]) begin
        errors++; $display("FAIL load_%0d data lv=%b got=%h exp=%h", i, o.lv, o.ld, exs[i]);
      end
      checks++; if (o.lat !== 3) begin
        errors++; $display("FAIL load_%0d latency got=%0d exp=3", i, o.lat);
      end
      checks++; if ({o.stall_acc, o.stall_busy_ok, o.stall_end} !== 3'b110) begin
        errors++; $display("FAIL load_%0d stall acc/busy/end got=%b exp=110", i, {o.stall_acc, o.stall_busy_ok, o.stall_end});
      end
      checks++; if (o.maddr !== 32'h100 || o.we !== 1'b0) begin
        errors++; $display("FAIL load_%0d bus addr=%h we=%b exp=00000100/0", i, o.maddr, o.we);
      end
      last_ld = exs[i];
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_txn(1'b1, 3'b000, 32'h201, 32'h0000005A, 32'hDEAD0000, 0, 0, o);
    checks++; if (o.strb !== 4'b0010 || o.mwdata !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL sb_lanes strb=%b wdata=%h exp=0010/5a5a5a5a", o.strb, o.mwdata);
    end
    checks++; if (o.maddr !== 32'h200 || o.we !== 1'b1) begin
      errors++; $display("FAIL sb_addr addr=%h we=%b exp=00000200/1", o.maddr, o.we);
    end
    checks++; if (o.lv !== 1'b0 || o.ld !== last_ld) begin
      errors++; $display("FAIL sb_noload lv=%b ld=%h exp=0/%h", o.lv, o.ld, last_ld);
    end
  endtask

  task automatic test_faults();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.f !== 1'b1 || o.fc !== 2'b01 || o.lat !== 1) begin
      errors++; $display("FAIL misalign f=%b code=%b lat=%0d exp=1/01/1", o.f, o.fc, o.lat);
    end
    checks++; if (o.saw_valid !== 1'b0 || o.stall_end !== 1'b0) begin
      errors++; $display("FAIL misalign_bus mem_valid_seen=%b stall=%b exp=0/0", o.saw_valid, o.stall_end);
    end
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.f !== 1'b1 || o.fc !== 2'b10 || o.saw_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_size f=%b code=%b mv=%b exp=1/10/0", o.f, o.fc, o.saw_valid);
    end
    step();
    checks++; if (fault !== 1'b0 || fault_code !== 2'b10) begin
      errors++; $display("FAIL code_hold fault=%b code=%b exp=0/10", fault, fault_code);
    end
  endtask

  task automatic test_ready_stall();
    obs_t o;
    run_txn(1'b1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 10, 0, o);
    checks++; if (o.stable !== 1'b1 || o.f !== 1'b0 || o.lat !== 13) begin
      errors++; $display("FAIL ready_stall stable=%b fault=%b lat=%0d exp=1/0/13", o.stable, o.f, o.lat);
    end
    checks++; if (o.strb !== 4'b1100 || o.mwdata !== 32'hBEEFBEEF || o.stall_busy_ok !== 1'b1) begin
      errors++; $display("FAIL ready_stall_payload strb=%b wdata=%h busy=%b exp=1100/beefbeef/1", o.strb, o.mwdata, o.stall_busy_ok);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'hDEADBEEF, 0, TO - 1, o);
    checks++; if (o.f !== 1'b0 || o.lv !== 1'b1 || o.ld !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rvalid_wins fault=%b lv=%b ld=%h exp=0/1/deadbeef", o.f, o.lv, o.ld);
    end
    last_ld = 32'hDEADBEEF;
    run_txn(1'b0, 3'b010, 32'h404, 32'h0, 32'h12345678, 0, TO + 50, o);
    checks++; if (o.f !== 1'b1 || o.fc !== 2'b11 || o.wait_cyc !== TO) begin
      errors++; $display("FAIL timeout f=%b code=%b wait=%0d exp=1/11/%0d", o.f, o.fc, o.wait_cyc, TO);
    end
    checks++; if (o.hung !== 1'b0 || load_data !== last_ld) begin
      errors++; $display("FAIL timeout_hold hung=%b ld=%h exp=0/%h", o.hung, load_data, last_ld);
    end
  endtask

  task automatic test_rvalid_idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
    step(); step();
    mem_rvalid = 1'b0;
    checks++; if (load_valid !== 1'b0 || core_stall !== 1'b0 || load_data !== last_ld) begin
      errors++; $display("FAIL rvalid_idle lv=%b stall=%b ld=%h exp=0/0/%h", load_valid, core_stall, load_data, last_ld);
    end
    step();
  endtask

  task automatic test_random();
    obs_t        o;
    logic        st;
    logic [2:0]  sz;
    logic [31:0] a, wd, rd, e_ld;
    logic [1:0]  e_fc;
    int          rdy, rsp;
    logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(size_bytes(sz)) - 32'd1);
      wd  = $urandom; rd = $urandom;
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      e_fc = model_fault(st, sz, a);
      run_txn(st, sz, a, wd, rd, rdy, rsp, o);
      if (e_fc != 2'b00) begin
        checks++; if (o.f !== 1'b1 || o.fc !== e_fc || o.saw_valid !== 1'b0 || o.lat !== 1) begin
          errors++; $display("FAIL rnd%0d_fault f=%b code=%b mv=%b lat=%0d exp=1/%b/0/1", i, o.f, o.fc, o.saw_valid, o.lat, e_fc);
        end
      end else begin
        e_ld = st ? last_ld : model_load(sz, a, rd);
        checks++; if (o.f !== 1'b0 || o.lv !== !st || o.ld !== e_ld || o.lat !== 3 + rdy + rsp) begin
          errors++; $display("FAIL rnd%0d_result f=%b lv=%b ld=%h lat=%0d exp=0/%b/%h/%0d", i, o.f, o.lv, o.ld, o.lat, !st, e_ld, 3 + rdy + rsp);
        end
        checks++; if (o.maddr !== {a[31:2], 2'b00} || o.we !== st || o.stable !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_bus addr=%h we=%b stable=%b exp=%h/%b/1", i, o.maddr, o.we, o.stable, {a[31:2], 2'b00}, st);
        end
        if (st) begin
          checks++; if (o.strb !== model_strb(sz, a) || o.mwdata !== model_wdata(sz, wd)) begin
            errors++; $display("FAIL rnd%0d_store strb=%b wdata=%h exp=%b/%h", i, o.strb, o.mwdata, model_strb(sz, a), model_wdata(sz, wd));
          end
        end
        checks++; if ({o.stall_acc, o.stall_busy_ok, o.stall_end} !== 3'b110) begin
          errors++; $display("FAIL rnd%0d_stall got=%b exp=110", i, {o.stall_acc, o.stall_busy_ok, o.stall_end});
        end
        last_ld = e_ld;
      end
    end
  endtask

  task automatic test_midop_reset();
    req_valid = 1'b1; req_store = 1'b0; req_size = 3'b010; req_addr = 32'h500;
    #1 step();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({core_stall, mem_valid, load_valid, fault} !== 4'b0 || load_data !== 32'h0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL midop_reset stall=%b mv=%b lv=%b f=%b ld=%h fc=%b exp=0", core_stall, mem_valid, load_valid, fault, load_data, fault_code);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (load_valid !== 1'b0 || core_stall !== 1'b0 || load_data !== 32'h0) begin
        errors++; $display("FAIL late_rvalid_%0d lv=%b stall=%b ld=%h exp=0/0/0", i, load_valid, core_stall, load_data);
      end
      step();
    end
    last_ld = '0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_faults();
    test_ready_stall();
    test_timeout();
    test_rvalid_idle();
    test_random();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
